// File: rtl/voxel_raster_lanes.sv
// voxel_raster_lanes: LANES adjacent rays of one screen row are slab-tested against a
// streamed voxel list (one voxel per cycle), then coloured from a streamed palette.
module voxel_raster_lanes #(
  parameter int LANES        = 4,
  parameter int ROW          = 0,
  parameter int COL_BASE     = 0,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int FRAC_BITS    = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter logic [PIXEL_BITS-1:0] BACKGROUND = '0,
  localparam int W = COORD_BITS + FRAC_BITS
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    raster_start_i,
  input  logic                    shade_start_i,
  input  logic                    voxel_valid_i,
  input  logic                    voxel_last_i,
  output logic                    voxel_ready_o,
  input  logic [COORD_BITS-1:0]   voxel_x_i,
  input  logic [COORD_BITS-1:0]   voxel_y_i,
  input  logic [COORD_BITS-1:0]   voxel_z_i,
  input  logic [PALETTE_BITS-1:0] voxel_id_i,
  input  logic [W-1:0]            cam_pos_x_i,
  input  logic [W-1:0]            cam_pos_y_i,
  input  logic [W-1:0]            cam_pos_z_i,
  input  logic [LANES*W-1:0]      inv_dir_x_i,
  input  logic [LANES*W-1:0]      inv_dir_y_i,
  input  logic [LANES*W-1:0]      inv_dir_z_i,
  input  logic                    palette_valid_i,
  input  logic                    palette_last_i,
  input  logic [PALETTE_BITS-1:0] palette_id_i,
  input  logic [PIXEL_BITS-1:0]   palette_entry_i,
  input  logic [ROW_BITS-1:0]     row_i,
  input  logic [COL_BITS-1:0]     col_i,
  output logic [PIXEL_BITS-1:0]   pixel_o,
  output logic                    raster_done_o,
  output logic                    shading_done_o
);

  // Offsets carry two extra bits so voxel+1 at the top of the grid never wraps.
  localparam int AW = W + 2;
  localparam int PW = AW + W;
  localparam logic signed [W-1:0]  T_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  T_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  T_NMAX = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] ZERO_A = '0;
  localparam logic signed [W-1:0]  ZERO_T = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_RASTER, S_DRAIN, S_DONE_RASTER, S_SHADE, S_DONE_SHADE
  } state_e;

  state_e     state_q;
  logic [1:0] drain_cnt_q;
  logic       voxel_ready_q, raster_done_q, shading_done_q;
  logic       voxel_acc, palette_acc, raster_go, shade_go;

  assign voxel_acc   = voxel_valid_i && voxel_ready_q;
  assign raster_go   = (state_q == S_IDLE) && raster_start_i;
  assign shade_go    = (state_q == S_IDLE) && shade_start_i && !raster_start_i;
  assign palette_acc = (state_q == S_SHADE) && palette_valid_i;

  assign voxel_ready_o  = voxel_ready_q;
  assign raster_done_o  = raster_done_q;
  assign shading_done_o = shading_done_q;

  // Done pulses trail the DONE states by one cycle, so the last hit update is settled.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= S_IDLE;
      drain_cnt_q    <= '0;
      voxel_ready_q  <= 1'b0;
      raster_done_q  <= 1'b0;
      shading_done_q <= 1'b0;
    end else begin
      raster_done_q  <= (state_q == S_DONE_RASTER);
      shading_done_q <= (state_q == S_DONE_SHADE);
      case (state_q)
        S_IDLE: begin
          if (raster_go) begin
            state_q       <= S_RASTER;
            voxel_ready_q <= 1'b1;
          end else if (shade_go) begin
            state_q <= S_SHADE;
          end
        end
        S_RASTER: begin
          if (voxel_acc && voxel_last_i) begin
            state_q       <= S_DRAIN;
            voxel_ready_q <= 1'b0;
            drain_cnt_q   <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == 2'd2) state_q <= S_DONE_RASTER;
          else drain_cnt_q <= drain_cnt_q + 2'd1;
        end
        S_DONE_RASTER: state_q <= S_IDLE;
        S_SHADE: begin
          if (palette_acc && palette_last_i) state_q <= S_DONE_SHADE;
        end
        S_DONE_SHADE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic signed [W-1:0] scale(input logic signed [AW-1:0] d,
                                                input logic signed [W-1:0]  inv);
    logic signed [PW-1:0] p;
    p = (PW'(d) * PW'(inv)) >>> FRAC_BITS;
    if (p > PW'(T_MAX))      scale = T_MAX;
    else if (p < PW'(T_MIN)) scale = T_MIN;
    else                     scale = p[W-1:0];
  endfunction

  logic [COORD_BITS-1:0]  vox    [3];
  logic [COORD_BITS:0]    vox_p1 [3];
  logic signed [W-1:0]    cam    [3];
  logic [LANES*W-1:0]     inv_bus[3];
  logic signed [AW-1:0]   s1_a_d [3];
  logic signed [AW-1:0]   s1_b_d [3];

  always_comb begin
    vox[0] = voxel_x_i;
    vox[1] = voxel_y_i;
    vox[2] = voxel_z_i;
    cam[0] = $signed(cam_pos_x_i);
    cam[1] = $signed(cam_pos_y_i);
    cam[2] = $signed(cam_pos_z_i);
    inv_bus[0] = inv_dir_x_i;
    inv_bus[1] = inv_dir_y_i;
    inv_bus[2] = inv_dir_z_i;
    for (int ax = 0; ax < 3; ax++) begin
      vox_p1[ax] = (COORD_BITS+1)'(vox[ax]) + (COORD_BITS+1)'(1);
      s1_a_d[ax] = $signed({2'b00, vox[ax], {FRAC_BITS{1'b0}}}) - AW'(cam[ax]);
      s1_b_d[ax] = $signed({1'b0, vox_p1[ax], {FRAC_BITS{1'b0}}}) - AW'(cam[ax]);
    end
  end

  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  logic [PALETTE_BITS-1:0] s1_id_q, s2_id_q, s3_id_q;
  logic signed [AW-1:0]    s1_a_q [3];
  logic signed [AW-1:0]    s1_b_q [3];
  logic signed [W-1:0]     lo_d [LANES][3];
  logic signed [W-1:0]     hi_d [LANES][3];
  logic                    miss_d [LANES];
  logic signed [W-1:0]     s2_lo_q [LANES][3];
  logic signed [W-1:0]     s2_hi_q [LANES][3];
  logic                    s2_miss_q [LANES];
  logic signed [W-1:0]     enter_d [LANES];
  logic signed [W-1:0]     exit_d  [LANES];
  logic signed [W-1:0]     s3_enter_q [LANES];
  logic signed [W-1:0]     s3_exit_q  [LANES];
  logic                    s3_miss_q  [LANES];

  always_comb begin
    logic signed [W-1:0] inv, ta, tb;
    inv = '0;
    ta  = '0;
    tb  = '0;
    for (int l = 0; l < LANES; l++) begin
      miss_d[l] = 1'b0;
      for (int ax = 0; ax < 3; ax++) begin
        inv = $signed(inv_bus[ax][l*W +: W]);
        ta  = scale(s1_a_q[ax], inv);
        tb  = scale(s1_b_q[ax], inv);
        if (inv == ZERO_T) begin
          // Parallel ray: the slab is unbounded only if the origin already lies inside it.
          lo_d[l][ax] = T_NMAX;
          hi_d[l][ax] = T_MAX;
          if (!(s1_a_q[ax] <= ZERO_A && s1_b_q[ax] > ZERO_A)) miss_d[l] = 1'b1;
        end else begin
          lo_d[l][ax] = (ta < tb) ? ta : tb;
          hi_d[l][ax] = (ta < tb) ? tb : ta;
        end
      end
      enter_d[l] = s2_lo_q[l][0];
      exit_d[l]  = s2_hi_q[l][0];
      for (int ax = 1; ax < 3; ax++) begin
        if (s2_lo_q[l][ax] > enter_d[l]) enter_d[l] = s2_lo_q[l][ax];
        if (s2_hi_q[l][ax] < exit_d[l])  exit_d[l]  = s2_hi_q[l][ax];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s2_id_q    <= '0;
      s3_id_q    <= '0;
      for (int ax = 0; ax < 3; ax++) begin
        s1_a_q[ax] <= '0;
        s1_b_q[ax] <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        s2_miss_q[l]  <= 1'b0;
        s3_miss_q[l]  <= 1'b0;
        s3_enter_q[l] <= '0;
        s3_exit_q[l]  <= '0;
        for (int ax = 0; ax < 3; ax++) begin
          s2_lo_q[l][ax] <= '0;
          s2_hi_q[l][ax] <= '0;
        end
      end
    end else begin
      s1_valid_q <= voxel_acc;
      s1_id_q    <= voxel_id_i;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      s2_lo_q    <= lo_d;
      s2_hi_q    <= hi_d;
      s2_miss_q  <= miss_d;
      s3_valid_q <= s2_valid_q;
      s3_id_q    <= s2_id_q;
      s3_enter_q <= enter_d;
      s3_exit_q  <= exit_d;
      s3_miss_q  <= s2_miss_q;
    end
  end

  logic signed [W-1:0]     closest_t_q  [LANES];
  logic [PALETTE_BITS-1:0] closest_id_q [LANES];
  logic                    hit_q        [LANES];
  logic [PIXEL_BITS-1:0]   pix_q        [LANES];
  logic                    hit_now      [LANES];

  // Strict less-than keeps the earlier-streamed voxel on an equal-t tie.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      hit_now[l] = s3_valid_q && !s3_miss_q[l] && (s3_enter_q[l] <= s3_exit_q[l]) &&
                   (s3_exit_q[l] >= ZERO_T) && (s3_enter_q[l] < closest_t_q[l]);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int l = 0; l < LANES; l++) begin
        closest_t_q[l]  <= T_MAX;
        closest_id_q[l] <= '0;
        hit_q[l]        <= 1'b0;
        pix_q[l]        <= BACKGROUND;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (raster_go) begin
          closest_t_q[l]  <= T_MAX;
          closest_id_q[l] <= '0;
          hit_q[l]        <= 1'b0;
        end else if (hit_now[l]) begin
          closest_t_q[l]  <= s3_enter_q[l];
          closest_id_q[l] <= s3_id_q;
          hit_q[l]        <= 1'b1;
        end
        if (shade_go && !hit_q[l]) begin
          pix_q[l] <= BACKGROUND;
        end else if (palette_acc && hit_q[l] && (closest_id_q[l] == palette_id_i)) begin
          pix_q[l] <= palette_entry_i;
        end
      end
    end
  end

  logic                  rd_sel;
  logic [PIXEL_BITS-1:0] rd_val;

  always_comb begin
    rd_sel = 1'b0;
    rd_val = '0;
    for (int l = 0; l < LANES; l++) begin
      if (row_i == ROW_BITS'(ROW) && col_i == COL_BITS'(COL_BASE + l)) begin
        rd_sel = 1'b1;
        rd_val = pix_q[l];
      end
    end
  end

  assign pixel_o = rd_sel ? rd_val : {PIXEL_BITS{1'bz}};

endmodule

// File: doc/voxel_raster_lanes.md
# voxel_raster_lanes

Multi-lane successor to the single-pixel shader. One instance owns `LANES` adjacent pixels of one screen row. It intersects a streamed voxel list against one ray per lane with a fully pipelined slab test, using multiplies by precomputed inverse direction instead of iterative division. At one voxel per cycle it keeps per-lane closest-hit state, then resolves colours from a streamed palette. It sits in the same row/column pixel-readout fabric as the existing shader array.

## Interface
- `LANES`, 4, pixels (rays) per instance.
- `ROW`, 0, screen row owned.
- `COL_BASE`, 0, first column owned; lane i owns column `COL_BASE+i`.
- `ROW_BITS` / `COL_BITS`, 8 / 8, readout address widths.
- `COORD_BITS`, 8, unsigned voxel coordinate width.
- `FRAC_BITS`, 8, fixed-point fraction bits; `W = COORD_BITS+FRAC_BITS`, signed.
- `PALETTE_BITS` / `PIXEL_BITS`, 8 / 8, voxel id and colour widths.
- `BACKGROUND`, 0, colour for lanes with no hit.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `raster_start` in 1: pulse; clears hit state and begins rasterizing (IDLE only).
- `shade_start` in 1: pulse; begins shading (IDLE only).
- `voxel_valid`, `voxel_last` in 1 each: voxel stream beat and final-beat flag.
- `voxel_ready` out 1: voxel beat accepted when `voxel_valid && voxel_ready`.
- `voxel_x`/`voxel_y`/`voxel_z` in COORD_BITS each; `voxel_id` in PALETTE_BITS.
- `cam_pos_x/y/z` in W each: shared ray origin, signed fixed point.
- `inv_dir_x/y/z` in LANES*W each: per-lane 1/direction; lane i at bits [i*W +: W]; 0 means ray parallel to that axis.
- `palette_valid`, `palette_last` in 1 each; `palette_id` in PALETTE_BITS; `palette_entry` in PIXEL_BITS.
- `row` in ROW_BITS, `col` in COL_BITS: readout address.
- `pixel` out PIXEL_BITS tri-state: lane colour when `row==ROW` and `col` is in `[COL_BASE, COL_BASE+LANES)`, else `'z`.
- `raster_done`, `shading_done` out 1: one-cycle done pulses.

## Operation
- **States:** IDLE, RASTER, DRAIN, DONE_RASTER, SHADE, DONE_SHADE.
  - IDLE→RASTER on `raster_start`; this also clears every lane: `closest_t` = max positive W, `hit` = 0, `closest_id` = 0.
  - IDLE→SHADE on `shade_start`. If both are asserted, `raster_start` wins.
  - RASTER→DRAIN after accepting the `voxel_last` beat.
  - DRAIN lasts 3 cycles, then →DONE_RASTER (1 cycle, `raster_done`=1) →IDLE.
  - SHADE→DONE_SHADE after a `palette_last` beat; DONE_SHADE lasts 1 cycle (`shading_done`=1), then →IDLE.
  - Start pulses outside IDLE are ignored.
- **`voxel_ready`:** 1 only in RASTER. Beats offered in other states are not consumed.
- **Pipeline stage 1:** register `A = {voxel, 0} - cam_pos` and `B = {voxel+1, 0} - cam_pos` per axis, plus the id and a valid bit. Bubbles propagate as invalid.
- **Pipeline stage 2 (per lane, per axis):** `tA = (A*inv) >>> FRAC_BITS` and `tB = (B*inv) >>> FRAC_BITS`.
  - The 2W product is saturated to W.
  - Register `lo = min(tA,tB)` and `hi = max(tA,tB)`.
  - If `inv==0`: slab is `(-max, +max)` when `A <= 0 < B` (origin inside the slab), else mark that lane/voxel as a miss.
- **Pipeline stage 3 (per lane):** `t_enter = max(lo)`, `t_exit = min(hi)`.
  - Hit iff there is no miss mark, `t_enter <= t_exit`, `t_exit >= 0`, and `t_enter < closest_t`.
  - On hit: `closest_t <= t_enter`, `closest_id <= id`, `hit <= 1`.
  - Strict compare: on equal t, the earlier-streamed voxel wins.
- **SHADE:**
  - On entry, lanes with `hit==0` load `BACKGROUND`.
  - Each `palette_valid` beat: lanes with `hit && closest_id==palette_id` load `palette_entry`. A later matching beat overwrites.
- **Reset values:** `state` = IDLE; all `closest_t` = max positive; `hit`/`closest_id` = 0; lane pixels = `BACKGROUND`; `voxel_ready`, `raster_done`, `shading_done` = 0.
- **Reset mid-operation:** aborts immediately, flushes pipeline valids, and restores all reset values.

## Timing
- `raster_start` sampled at edge k; `voxel_ready`=1 from cycle k+1.
- Throughput is 1 voxel/cycle, no stalls. A voxel accepted at edge n updates `closest_*` at edge n+3.
- `voxel_last` accepted at edge n: `voxel_ready`=0 from n+1, and `raster_done` is high for the cycle after edge n+4. All updates are visible before `raster_done`.
- Palette beat at edge m: pixel updated at edge m. `palette_last` at edge m: `shading_done` is high for the cycle after edge m+1.
- `pixel` readout is combinational from `row`/`col`.

## Test plan
- **Basic hit, nearer voxel wins:** FRAC=8, `cam_pos` = (0x0080, 0x0080, -0x0200), lane 0 `inv` = (0, 0, 0x0100); stream voxel (0,0,5) id 7, then (0,0,0) id 5 last; palette 5→0xAA, 7→0xBB. Expect lane-0 pixel 0xAA, `closest_t` 0x0200, `raster_done` 4 cycles after the last beat.
- **Equal-t tie:** same voxel (0,0,0) streamed as id 3 then id 4. Expect `closest_id` = 3.
- **Voxel behind camera:** `cam_pos_z` = 0x0A00, +z ray. Expect no hit; shading gives `BACKGROUND`.
- **Parallel-axis miss:** `cam_pos_x` = 0x0180 with `inv_x` = 0, voxel x = 0. Expect miss; lane 1 with a different `inv` vector hits independently.
- **Stream gaps and ignored starts:** `voxel_valid` toggling every other cycle; `voxel_valid` held during DRAIN; `shade_start` pulsed during RASTER. Expect identical results, no extra beats consumed, `shade_start` ignored.
- **Reset mid-RASTER:** `reset_n` low for 1 cycle after 2 beats. Expect IDLE, `hit`=0, pixels = `BACKGROUND`, `voxel_ready`=0, no done pulse.
